// File: rtl/lpc_io_pkg.sv
// Shared constants, target indices and state encoding for the LPC I/O arbiter.
package lpc_io_pkg;

  localparam logic [15:0] POST_ADDR = 16'h0080;
  localparam logic [15:0] COM0_BASE = 16'h03F8;
  localparam logic [15:0] COM1_BASE = 16'h02F8;

  localparam int TGT_POST = 0;
  localparam int TGT_COM0 = 1;
  localparam int TGT_COM1 = 2;
  localparam int TGT_GPIO = 3;
  localparam int N_TGT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } lpc_state_t;

  function automatic logic in_window8(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:3] == base[15:3];
  endfunction

endpackage

// File: rtl/lpc_io_arbiter_if.sv
// Host-side backend bus plus target-side strobes of the LPC I/O arbiter.
interface lpc_io_arbiter_if;
  logic        lpc_en;
  logic [15:0] lpc_addr;
  logic        io_rden;
  logic        io_wren;
  logic [7:0]  lpc_wdata;
  logic        addr_hit;
  logic [7:0]  lpc_rdata;
  logic        lpc_done;
  logic        lpc_err;
  logic        busy;
  logic [3:0]  dev_cs;
  logic [2:0]  dev_addr;
  logic [7:0]  dev_wdata;
  logic        dev_rden;
  logic        dev_wren;
  logic [3:0]  dev_ack;
  logic [31:0] dev_rdata;

  modport slave (
    input  lpc_en, lpc_addr, io_rden, io_wren, lpc_wdata, dev_ack, dev_rdata,
    output addr_hit, lpc_rdata, lpc_done, lpc_err, busy,
           dev_cs, dev_addr, dev_wdata, dev_rden, dev_wren
  );

  modport master (
    output lpc_en, lpc_addr, io_rden, io_wren, lpc_wdata, dev_ack, dev_rdata,
    input  addr_hit, lpc_rdata, lpc_done, lpc_err, busy,
           dev_cs, dev_addr, dev_wdata, dev_rden, dev_wren
  );
endinterface

// File: rtl/lpc_addr_decode.sv
// Combinational I/O address decode: window hit, one-hot target select, offset.
// COM1 window is decoded only when LPC_COM1_EN is defined.
module lpc_addr_decode
  import lpc_io_pkg::*;
#(
  parameter logic [15:0] GPIO_BASE = 16'h0A00
) (
  input  logic [15:0] addr_i,
  output logic        hit_o,
  output logic [3:0]  sel_o,
  output logic [2:0]  offset_o
);

  always_comb begin
    sel_o           = '0;
    sel_o[TGT_POST] = (addr_i == POST_ADDR);
    sel_o[TGT_COM0] = in_window8(addr_i, COM0_BASE);
`ifdef LPC_COM1_EN
    sel_o[TGT_COM1] = in_window8(addr_i, COM1_BASE);
`else
    sel_o[TGT_COM1] = 1'b0;
`endif
    // fixed windows win if GPIO_BASE is misplaced on top of one, keeping sel one-hot
    sel_o[TGT_GPIO] = in_window8(addr_i, GPIO_BASE) & ~(|sel_o[2:0]);
    hit_o           = |sel_o;
    offset_o        = sel_o[TGT_POST] ? 3'd0 : addr_i[2:0];
  end

endmodule

// File: rtl/lpc_io_arbiter.sv
// LPC I/O arbiter: routes backend I/O cycles to POST/COM0/COM1/GPIO targets with ack timeout.
// States: IDLE wait for request | ACCESS strobe target | WAIT await ack | DONE completion pulse
module lpc_io_arbiter
  import lpc_io_pkg::*;
#(
  parameter int unsigned  TIMEOUT_CYCLES = 8,
  parameter logic [15:0]  GPIO_BASE      = 16'h0A00
) (
  input  logic             lclk,
  input  logic             lreset_n,
  lpc_io_arbiter_if.slave  bus
);

  localparam logic [7:0] TO_LIMIT = TIMEOUT_CYCLES[7:0];

  lpc_state_t  state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  cs_q;
  logic [2:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        is_rd_q;
  logic        rden_q;
  logic        wren_q;
  logic        done_q;
  logic        err_q;
  logic [7:0]  rdata_q;

  logic        hit;
  logic [3:0]  sel;
  logic [2:0]  offset;
  logic        req_ok;
  logic        ack_sel;
  logic [7:0]  rd_byte;

  lpc_addr_decode #(.GPIO_BASE(GPIO_BASE)) u_decode (
    .addr_i   (bus.lpc_addr),
    .hit_o    (hit),
    .sel_o    (sel),
    .offset_o (offset)
  );

  assign req_ok  = bus.lpc_en & hit & (bus.io_rden ^ bus.io_wren);
  assign ack_sel = |(bus.dev_ack & cs_q);

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (cs_q[i]) rd_byte = bus.dev_rdata[i*8 +: 8];
    end
  end

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_rd_q <= 1'b0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'hFF;
    end else begin
      rden_q <= 1'b0;
      wren_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_ok) begin
            state_q <= ST_ACCESS;
            cnt_q   <= '0;
            cs_q    <= sel;
            addr_q  <= offset;
            wdata_q <= bus.lpc_wdata;
            is_rd_q <= bus.io_rden;
            rden_q  <= bus.io_rden;
            wren_q  <= bus.io_wren;
          end
        end
        ST_ACCESS, ST_WAIT: begin
          if (ack_sel) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            cs_q    <= '0;
            if (is_rd_q) rdata_q <= rd_byte;
          end else if (state_q == ST_WAIT && cnt_q == TO_LIMIT) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            cs_q    <= '0;
            if (is_rd_q) rdata_q <= 8'hFF;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.addr_hit  = hit;
  assign bus.lpc_rdata = rdata_q;
  assign bus.lpc_done  = done_q;
  assign bus.lpc_err   = err_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.dev_cs    = cs_q;
  assign bus.dev_addr  = addr_q;
  assign bus.dev_wdata = wdata_q;
  assign bus.dev_rden  = rden_q;
  assign bus.dev_wren  = wren_q;

endmodule

// File: doc/lpc_io_arbiter.md
LPC_IO_ARBITER -- requirements
Module: lpc_io_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8: max cycles to wait for target ack (legal 1..255).
REQ-002 Parameter GPIO_BASE, default 16'h0A00: base of 8-byte GPIO window (8-aligned).
REQ-003 lclk  input  1  LPC clock (33 MHz); sole clock.
REQ-004 lreset_n  input  1  asynchronous, active-low reset.
REQ-005 lpc_en  input  1  backend bus valid from LPC front end.
REQ-006 lpc_addr  input  16  I/O address of current cycle.
REQ-007 io_rden / io_wren  input  1 each  one-cycle read/write request pulses.
REQ-008 lpc_wdata  input  8  write data from host.
REQ-009 addr_hit  output  1  combinational: lpc_addr inside an enabled window.
REQ-010 lpc_rdata  output  8  read data to front end.
REQ-011 lpc_done  output  1  one-cycle completion pulse.
REQ-012 lpc_err  output  1  one-cycle timeout pulse, coincident with lpc_done.
REQ-013 busy  output  1  high while a transaction is outstanding.
REQ-014 dev_cs  output  4  one-hot target select: [0] POST 0x080, [1] COM0 0x3F8-0x3FF, [2] COM1 0x2F8-0x2FF, [3] GPIO.
REQ-015 dev_addr  output  3  offset within window (0 for POST).
REQ-016 dev_wdata  output  8  latched write data.
REQ-017 dev_rden / dev_wren  output  1 each  one-cycle target strobes.
REQ-018 dev_ack  input  4  per-target completion.
REQ-019 dev_rdata  input  32  target read data, byte i from target i.

Function
REQ-020 States IDLE, ACCESS, WAIT, DONE; encoding from shared package.
REQ-021 IDLE: lpc_en & addr_hit & exactly one of io_rden/io_wren -> latch addr, offset, wdata, direction, target; next ACCESS.
REQ-022 io_rden and io_wren both high, miss, or lpc_en low -> no transaction, stay IDLE.
REQ-023 ACCESS (one cycle): dev_rden or dev_wren high, dev_cs one-hot held from ACCESS through WAIT; next WAIT unless ack.
REQ-024 Ack of selected target in ACCESS or WAIT -> capture dev_rdata byte (reads only), next DONE; acks from unselected targets ignored.
REQ-025 Minimum latency: request cycle N, strobe N+1, ack N+1, lpc_done N+2.
REQ-026 WAIT counter 8-bit, cleared on ACCESS entry; counter == TIMEOUT_CYCLES without ack -> lpc_rdata 8'hFF (reads), lpc_err pulse, DONE.
REQ-027 DONE (one cycle): lpc_done high, dev_cs cleared; next IDLE.
REQ-028 Writes leave lpc_rdata unchanged.
REQ-029 Requests arriving while busy are dropped, no queueing.
REQ-030 busy high in ACCESS, WAIT, DONE.

Reset
REQ-031 lreset_n low: state IDLE, counter 0, dev_cs 0, strobes 0, lpc_done 0, lpc_err 0, busy 0, lpc_rdata 8'hFF, dev_addr 0, dev_wdata 0.
REQ-032 Reset mid-transaction aborts immediately; no lpc_done issued; target sees cs drop.

Configuration
REQ-033 Macro LPC_COM1_EN defined: COM1 window decoded, dev_cs[2] usable.
REQ-034 LPC_COM1_EN undefined: 0x2F8-0x2FF misses (addr_hit 0), dev_cs[2] tied 0, dev_ack[2] ignored.

Structure
REQ-035 Package lpc_io_pkg: window base constants (0x080, 0x3F8, 0x2F8), target index constants, state enum.
REQ-036 Sub-module lpc_addr_decode: combinational address -> hit, one-hot select, offset; instantiated once.

Verification
REQ-037 Write 8'hA5 to 0x080, ack one cycle after strobe -> dev_cs=0001, dev_wren 1 cycle, dev_wdata=A5, lpc_done 3 cycles after request.
REQ-038 Read 0x3FD, ack 3 cycles after strobe, dev_rdata[15:8]=8'h60 -> dev_addr=5, lpc_rdata=60, lpc_err 0.
REQ-039 Read 0x3F8, no ack, TIMEOUT_CYCLES=8 -> lpc_rdata=FF, lpc_err and lpc_done same cycle, dev_cs cleared.
REQ-040 Read 0x2F8 with and without LPC_COM1_EN -> dev_cs=0100 vs. addr_hit 0 and no strobe.
REQ-041 io_rden+io_wren simultaneous to 0x080, and second request while busy -> no strobe / request dropped.
REQ-042 lreset_n low in WAIT -> all outputs reset values next edge, no lpc_done; next request served normally.
